// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encoding, default line parameters
// and the baud divisor helper used by both the transmitter and receiver.
package uart_pkg;

  localparam int FRE_DEF  = 50_000_000;
  localparam int BAUD_DEF = 115_200;

  localparam logic [5:0] ST_IDLE  = 6'b000001;
  localparam logic [5:0] ST_START = 6'b000010;
  localparam logic [5:0] ST_DATA  = 6'b000100;
  localparam logic [5:0] ST_STOP  = 6'b001000;
  localparam logic [5:0] ST_DONE  = 6'b010000;
  localparam logic [5:0] ST_ERR   = 6'b100000;

  typedef enum logic [5:0] {
    IDLE      = ST_IDLE,
    START_BIT = ST_START,
    DATA      = ST_DATA,
    STOP_BIT  = ST_STOP,
    DONE      = ST_DONE,
    ERR       = ST_ERR
  } uart_state_t;

  function automatic int bps_cnt(input int fre, input int baud);
    return fre / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line in, decoded byte and status strobes out.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;

  modport master (input rxd, output rx_data, output rx_done, output rx_err);
  modport slave  (output rxd, input rx_data, input rx_done, input rx_err);
endinterface

// File: rtl/uart_rx_chk.sv
// Protocol checks on the receiver status strobes.
module uart_rx_chk (
  input logic uclk,
  input logic rst_n,
  input logic rx_done,
  input logic rx_err
);

  a_done_single: assert property (@(posedge uclk) disable iff (!rst_n) rx_done |=> !rx_done);
  a_err_single:  assert property (@(posedge uclk) disable iff (!rst_n) rx_err |=> !rx_err);
  a_exclusive:   assert property (@(posedge uclk) disable iff (!rst_n) !(rx_done && rx_err));

  c_done: cover property (@(posedge uclk) disable iff (!rst_n) rx_done);
  c_err:  cover property (@(posedge uclk) disable iff (!rst_n) rx_err);
  c_excl: cover property (@(posedge uclk) disable iff (!rst_n) rx_done ##1 !rx_err);

endmodule

// File: rtl/uart_sync.sv
// Two-flop synchronizer plus one delay flop for an asynchronous input;
// provides the synchronized level and a falling-edge flag.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic uclk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic dly_r;

  // Synchronizer chain and edge-detect delay stage
  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      dly_r  <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      dly_r  <= sync_r;
    end
  end

  assign dout = sync_r;
  assign fall = dly_r & ~sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first assembly, one-cycle
// done/error strobes; a bad stop bit never disturbs the held byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FRE  = FRE_DEF,
  parameter int BAUD = BAUD_DEF
) (
  input logic      uclk,
  input logic      rst_n,
  uart_rx_if.master rx
);

  localparam int         BPS_CNT   = bps_cnt(FRE, BAUD);
  localparam int         HALF      = BPS_CNT / 2;
  localparam logic [15:0] BPS_LAST  = 16'(BPS_CNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  logic        rxd_s;
  logic        fall_s;
  uart_state_t state_r;
  uart_state_t next_state_s;
  logic [15:0] clk_cnt_r;
  logic [3:0]  data_cnt_r;
  logic [7:0]  shift_r;
  logic [7:0]  rx_data_r;
  logic        rx_done_r;
  logic        rx_err_r;
  logic        bps_hit_s;
  logic        half_hit_s;
  logic        done_s;
  logic        err_s;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .uclk  (uclk),
    .rst_n (rst_n),
    .din   (rx.rxd),
    .dout  (rxd_s),
    .fall  (fall_s)
  );

  assign bps_hit_s  = (clk_cnt_r == BPS_LAST);
  assign half_hit_s = (clk_cnt_r == HALF_LAST);
  assign done_s     = (state_r == STOP_BIT) && (next_state_s == DONE);
  assign err_s      = (state_r == STOP_BIT) && (next_state_s == ERR);

  // State register
  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; any non one-hot encoding falls back to IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (fall_s) next_state_s = START_BIT;
        else        next_state_s = IDLE;
      end
      START_BIT: begin
        if (half_hit_s) next_state_s = rxd_s ? IDLE : DATA;
        else            next_state_s = START_BIT;
      end
      DATA: begin
        if (bps_hit_s && (data_cnt_r == 4'd7)) next_state_s = STOP_BIT;
        else                                   next_state_s = DATA;
      end
      STOP_BIT: begin
        if (bps_hit_s) next_state_s = rxd_s ? DONE : ERR;
        else           next_state_s = STOP_BIT;
      end
      DONE: next_state_s = IDLE;
      ERR: begin
        if (rxd_s) next_state_s = IDLE;
        else       next_state_s = ERR;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Bit-period counter and data bit counter
  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_r  <= 16'd0;
      data_cnt_r <= 4'd0;
    end else begin
      if ((state_r == IDLE) || (next_state_s != state_r) || bps_hit_s) begin
        clk_cnt_r <= 16'd0;
      end else begin
        clk_cnt_r <= clk_cnt_r + 16'd1;
      end
      if (state_r != DATA) begin
        data_cnt_r <= 4'd0;
      end else if (bps_hit_s) begin
        data_cnt_r <= data_cnt_r + 4'd1;
      end else begin
        data_cnt_r <= data_cnt_r;
      end
    end
  end

  // LSB arrives first, so shift right and insert at the top
  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= 8'h00;
    end else if ((state_r == DATA) && bps_hit_s) begin
      shift_r <= {rxd_s, shift_r[7:1]};
    end else begin
      shift_r <= shift_r;
    end
  end

  // Registered outputs, the byte only updates on a good stop bit
  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r <= 8'h00;
      rx_done_r <= 1'b0;
      rx_err_r  <= 1'b0;
    end else begin
      rx_data_r <= done_s ? shift_r : rx_data_r;
      rx_done_r <= done_s;
      rx_err_r  <= err_s;
    end
  end

  assign rx.rx_data = rx_data_r;
  assign rx.rx_done = rx_done_r;
  assign rx.rx_err  = rx_err_r;

  uart_rx_chk u_chk (
    .uclk    (uclk),
    .rst_n   (rst_n),
    .rx_done (rx_done_r),
    .rx_err  (rx_err_r)
  );

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver; the receive-side counterpart of the team's UART transmitter, using the same 8N1 framing and baud parameters. Samples an asynchronous serial line `rxd` at mid-bit, assembles an 8-bit LSB-first byte, and presents it on `rx_data` with a one-cycle `rx_done` strobe. Framing errors are flagged on `rx_err` and never overwrite `rx_data`. Sits between the board-level UART pin and the command/loopback logic.

## Interface
- `FRE`, 50000000, uclk frequency in Hz
- `BAUD`, 115200, line rate; `BPS_CNT = FRE/BAUD` (434), `HALF = BPS_CNT/2` (217), integer division
- `uclk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rxd`  in  1  serial line, asynchronous to uclk, idle high
- `rx_data`  out  8  last correctly framed byte; held until next good frame
- `rx_done`  out  1  one-cycle pulse, `rx_data` valid from this cycle
- `rx_err`  out  1  one-cycle pulse, stop bit sampled low

## Operation
- `rxd` passes through a 2-FF synchronizer (`rxd_s`), then a delay flop (`rxd_d`); all three reset to 1. Falling edge = `rxd_d==1 && rxd_s==0`; tracked in every state.
- One-hot state (6 bits): IDLE, START_BIT, DATA, STOP_BIT, DONE, ERR; reset to IDLE; illegal encodings -> IDLE.
- IDLE: falling edge -> START_BIT. Edges in any other state are ignored.
- START_BIT: at `clk_cnt==HALF-1` sample `rxd_s`: 0 -> DATA; 1 (glitch) -> IDLE, no output activity.
- DATA: at `clk_cnt==BPS_CNT-1` shift `rxd_s` into `shift_r[7]` (right shift, LSB first), `data_cnt++`; after the 8th sample -> STOP_BIT.
- STOP_BIT: at `clk_cnt==BPS_CNT-1` sample `rxd_s`: 1 -> DONE, load `rx_data <= shift_r`; 0 -> ERR.
- DONE: `rx_done=1` for one cycle -> IDLE.
- ERR: `rx_err=1` on the first ERR cycle only; remain until `rxd_s==1`, then -> IDLE. Minimum one cycle in ERR.
- `clk_cnt` (16 bit): cleared in IDLE, on every state change, and on reaching its terminal count. `data_cnt` (4 bit): cleared outside DATA.
- Reset mid-frame: immediately IDLE, `rx_data=0`, `rx_done=0`, `rx_err=0`, counters 0. The remainder of the interrupted frame is not decoded unless a fresh falling edge is seen while in IDLE.

## Timing
- Reset values: `rx_data=8'h00`, `rx_done=0`, `rx_err=0`.
- Let D be the cycle in which IDLE detects the edge. Pin-to-detection latency is 2–3 cycles (synchronizer).
- State and sampling schedule:
  - START_BIT from D+1; start sample at D+217.
  - DATA from D+218; bit k (k=1..8) sampled at D+651+(k-1)·434.
  - STOP_BIT from D+3690; stop sample at D+4123.
  - DONE/ERR entered at D+4124; `rx_done` or `rx_err` high exactly at D+4124.
- Back-to-back frames: the next start edge arrives at least about HALF cycles after the stop sample, so it is caught in IDLE. No lost frame at the nominal baud rate.
- `rx_done` and `rx_err` are never high in the same cycle. Each is high for at most one cycle per frame.

## Structure
- Shared package `uart_pkg`:
  - state localparams (one-hot encoding, common with the transmitter);
  - `FRE`/`BAUD` defaults;
  - `bps_cnt(fre, baud)` function.
- Sub-module `uart_sync`: 2-FF synchronizer plus delay flop, outputs `rxd_s` and `fall`. Reusable for other async inputs.
- Embedded SVA:
  - `rx_done |=> !rx_done`;
  - `rx_err |=> !rx_err`;
  - `!(rx_done && rx_err)`;
  - cover for each.

## Test plan
- Frame 0x55 (bit period 434 cycles, stop=1) -> `rx_data=8'h55`, `rx_done` one cycle at D+4124, `rx_err=0`.
- Back-to-back frames 0xA3 then 0x0F, no idle gap -> two `rx_done` pulses 4340±3 cycles apart, `rx_data` 0xA3 then 0x0F.
- 100-cycle low glitch on idle line -> return to IDLE at D+218, no `rx_done`/`rx_err`, `rx_data` unchanged.
- Frame 0x3C with stop bit 0, line held low 1000 cycles, then frame 0x81 -> `rx_err` pulse at D+4124, `rx_data` stays at previous value; then `rx_data=8'h81` with `rx_done`.
- `rst_n` asserted in the middle of bit 4 of 0xFF -> outputs 0 immediately, no `rx_done` for that frame; following frame 0x12 received correctly.
- Loopback from the transmitter, `tx_data=8'hC6` -> `rx_data=8'hC6`, `rx_done` one cycle, no `rx_err`.
